// File: rtl/lock_controller.sv
// Combination-lock sequencer: digit entry against a programmable code, failed-attempt
// counting with timed lockout, and code re-programming from the open state.
module lock_controller #(
    parameter int unsigned         DIGITS         = 6,
    parameter int unsigned         MAX_FAIL       = 3,
    parameter int unsigned         LOCKOUT_CYCLES = 16,
    parameter logic [4*DIGITS-1:0] CODE_DEFAULT   = 24'h369561
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       lock_req,
    input  logic       prog_req,
    output logic       digit_ready,
    output logic [1:0] status,
    output logic [2:0] pos,
    output logic [1:0] fail_count,
    output logic       lockout,
    output logic [2:0] state
);

    localparam int unsigned CW   = 4 * DIGITS;
    localparam int unsigned CNTW = $clog2(LOCKOUT_CYCLES);

    localparam logic [2:0]      LAST_POS   = 3'(DIGITS - 1);
    localparam logic [2:0]      MAX_FAIL_W = 3'(MAX_FAIL);
    localparam logic [1:0]      MAX_FAIL_C = 2'(MAX_FAIL);
    localparam logic [CNTW-1:0] CNT_LOAD   = CNTW'(LOCKOUT_CYCLES - 1);

    localparam logic [1:0] STAT_OPEN    = 2'b00;
    localparam logic [1:0] STAT_CLOSED  = 2'b01;
    localparam logic [1:0] STAT_LEGAL   = 2'b11;
    localparam logic [1:0] STAT_ILLEGAL = 2'b10;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROG    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      pos_q, pos_d;
    logic [1:0]      fail_q, fail_d;
    logic            mism_q, mism_d;
    logic            ill_q, ill_d;
    logic [CW-1:0]   code_q, code_d;
    logic [CW-1:0]   shadow_q, shadow_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [1:0]      status_q, status_d;
    logic            ready_q, ready_d;
    logic            lockout_q, lockout_d;

    logic          accept;
    logic          digit_bad;
    logic [3:0]    exp_nib;
    logic [CW-1:0] shadow_wr;
    logic          mism_now;
    logic          ill_now;
    logic [2:0]    fail_plus;

    assign accept    = digit_valid & ready_q;
    assign digit_bad = (digit > 4'd9);
    assign fail_plus = {1'b0, fail_q} + 3'd1;

    // Code nibble for the current position; digit 0 lives in the most significant nibble.
    always_comb begin
        exp_nib   = '0;
        shadow_wr = shadow_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (pos_q == 3'(i)) begin
                exp_nib                            = code_q[4*(DIGITS-1-i) +: 4];
                shadow_wr[4*(DIGITS-1-i) +: 4] = digit;
            end
        end
    end

    assign mism_now = mism_q | digit_bad | (digit != exp_nib);
    assign ill_now  = ill_q | digit_bad;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        fail_d   = fail_q;
        mism_d   = mism_q;
        ill_d    = ill_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_ENTRY: begin
                if (accept) begin
                    if (pos_q == LAST_POS) begin
                        pos_d  = '0;
                        mism_d = 1'b0;
                        ill_d  = 1'b0;
                        if (!mism_now) begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                        end else if (fail_plus < MAX_FAIL_W) begin
                            state_d = ST_FAIL;
                            fail_d  = fail_plus[1:0];
                        end else begin
                            state_d = ST_LOCKOUT;
                            cnt_d   = CNT_LOAD;
                            fail_d  = MAX_FAIL_C;
                        end
                    end else begin
                        pos_d  = pos_q + 3'd1;
                        mism_d = mism_now;
                        ill_d  = ill_now;
                    end
                end
            end
            ST_OPEN: begin
                if (prog_req) begin
                    state_d = ST_PROG;
                    pos_d   = '0;
                end else if (lock_req) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_FAIL: begin
                state_d = ST_ENTRY;
            end
            ST_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PROG: begin
                if (accept) begin
                    if (digit_bad) begin
                        state_d = ST_OPEN;
                        pos_d   = '0;
                    end else if (pos_q == LAST_POS) begin
                        shadow_d = shadow_wr;
                        code_d   = shadow_wr;
                        state_d  = ST_ENTRY;
                        fail_d   = '0;
                        pos_d    = '0;
                    end else begin
                        shadow_d = shadow_wr;
                        pos_d    = pos_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_ENTRY;
                pos_d   = '0;
                mism_d  = 1'b0;
                ill_d   = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from next-state values so they register alongside the state.
    always_comb begin
        status_d  = STAT_LEGAL;
        ready_d   = 1'b0;
        lockout_d = 1'b0;
        case (state_d)
            ST_ENTRY: begin
                status_d = ill_d ? STAT_ILLEGAL : STAT_LEGAL;
                ready_d  = 1'b1;
            end
            ST_OPEN:    status_d = STAT_OPEN;
            ST_FAIL:    status_d = STAT_CLOSED;
            ST_LOCKOUT: begin
                status_d  = STAT_CLOSED;
                lockout_d = 1'b1;
            end
            ST_PROG: begin
                status_d = STAT_LEGAL;
                ready_d  = 1'b1;
            end
            default: begin
                status_d = STAT_LEGAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ENTRY;
            pos_q     <= '0;
            fail_q    <= '0;
            mism_q    <= 1'b0;
            ill_q     <= 1'b0;
            code_q    <= CODE_DEFAULT;
            shadow_q  <= CODE_DEFAULT;
            cnt_q     <= '0;
            status_q  <= STAT_LEGAL;
            ready_q   <= 1'b1;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            fail_q    <= fail_d;
            mism_q    <= mism_d;
            ill_q     <= ill_d;
            code_q    <= code_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            status_q  <= status_d;
            ready_q   <= ready_d;
            lockout_q <= lockout_d;
        end
    end

    assign digit_ready = ready_q;
    assign status      = status_q;
    assign pos         = pos_q;
    assign fail_count  = fail_q;
    assign lockout     = lockout_q;
    assign state       = state_q;

endmodule
